// File: rtl/mac_arb.sv
// mac_arb: two-requester arbiter and burst sequencer for a shared complex MAC.
// A granted requester gets one burst: alternating Q/I accumulate cycles that walk
// the sample buffer backwards and the coefficient ROM forwards (each coefficient
// is used for one Q and one I sample), followed by two output-dump cycles.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req[1:0]              level requests, held until the matching done pulse
//   r_start0/1 [PSZ]      newest buffer entry (Q word), captured at grant
//   c_base0/1  [CSZ]      first coefficient address, captured at grant
//   c_len0/1   [CSZ]      tap count minus one, captured at grant
//   gnt[1:0]              one-hot grant, high for the whole burst incl. dump
//   busy                  high whenever the sequencer is not idle
//   r_addr [PSZ]          buffer read address to the datapath
//   c_addr [CSZ]          coefficient read address to the datapath
//   mac_ena               accumulate enable
//   dump                  output-dump strobe
//   sel                   index of the granted requester
//   done[1:0]             one-cycle completion pulse per requester
//
// Build option: define MAC_ARB_FIXED_PRIO_EN to make requester 0 always win
// contention; otherwise contention is resolved round-robin.

module mac_arb #(
  parameter int unsigned PSZ = 9,
  parameter int unsigned CSZ = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req,
  input  logic [PSZ-1:0] r_start0,
  input  logic [PSZ-1:0] r_start1,
  input  logic [CSZ-1:0] c_base0,
  input  logic [CSZ-1:0] c_base1,
  input  logic [CSZ-1:0] c_len0,
  input  logic [CSZ-1:0] c_len1,
  output logic [1:0]     gnt,
  output logic           busy,
  output logic [PSZ-1:0] r_addr,
  output logic [CSZ-1:0] c_addr,
  output logic           mac_ena,
  output logic           dump,
  output logic           sel,
  output logic [1:0]     done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MACQ = 3'd1,
    MACI = 3'd2,
    DMPQ = 3'd3,
    DMPI = 3'd4
  } state_t;

  state_t         state;
  // Last coefficient address of the burst; the burst ends when c_addr reaches it.
  logic [CSZ-1:0] c_end;
  logic           win_c;

`ifndef MAC_ARB_FIXED_PRIO_EN
  logic           last;
`endif

  // Winner selection among the currently asserted requests.
  always_comb begin
    win_c = 1'b0;
`ifdef MAC_ARB_FIXED_PRIO_EN
    win_c = ~req[0];
`else
    case (req)
      2'b01:   win_c = 1'b0;
      2'b10:   win_c = 1'b1;
      2'b11:   win_c = ~last;
      default: win_c = 1'b0;
    endcase
`endif
  end

  // Sequencer state and registered datapath controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      busy    <= 1'b0;
      r_addr  <= '0;
      c_addr  <= '0;
      c_end   <= '0;
      mac_ena <= 1'b0;
      dump    <= 1'b0;
      sel     <= 1'b0;
      done    <= 2'b00;
`ifndef MAC_ARB_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= MACQ;
            gnt     <= win_c ? 2'b10 : 2'b01;
            sel     <= win_c;
            busy    <= 1'b1;
            mac_ena <= 1'b1;
            r_addr  <= win_c ? r_start1 : r_start0;
            c_addr  <= win_c ? c_base1 : c_base0;
            c_end   <= win_c ? CSZ'(c_base1 + c_len1) : CSZ'(c_base0 + c_len0);
          end
        end
        MACQ: begin
          r_addr <= r_addr - PSZ'(1);
          state  <= MACI;
        end
        MACI: begin
          if (c_addr != c_end) begin
            r_addr <= r_addr - PSZ'(1);
            c_addr <= c_addr + CSZ'(1);
            state  <= MACQ;
          end else begin
            mac_ena <= 1'b0;
            dump    <= 1'b1;
            state   <= DMPQ;
          end
        end
        DMPQ: begin
          state <= DMPI;
        end
        DMPI: begin
          done  <= sel ? 2'b10 : 2'b01;
          dump  <= 1'b0;
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
`ifndef MAC_ARB_FIXED_PRIO_EN
          last  <= sel;
`endif
        end
        default: begin
          state   <= IDLE;
          gnt     <= 2'b00;
          busy    <= 1'b0;
          mac_ena <= 1'b0;
          dump    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_arb.sv
// Self-checking bench for mac_arb: directed scenarios plus randomized bursts,
// compared cycle by cycle against a trace computed from the burst arithmetic.

module tb_mac_arb;

  localparam int unsigned PSZ = 9;
  localparam int unsigned CSZ = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req;
  logic [PSZ-1:0] r_start0, r_start1;
  logic [CSZ-1:0] c_base0, c_base1, c_len0, c_len1;
  logic [1:0]     gnt;
  logic           busy;
  logic [PSZ-1:0] r_addr;
  logic [CSZ-1:0] c_addr;
  logic           mac_ena;
  logic           dump;
  logic           sel;
  logic [1:0]     done;

  mac_arb #(.PSZ(PSZ), .CSZ(CSZ)) dut (
    .clk(clk), .reset(reset), .req(req),
    .r_start0(r_start0), .r_start1(r_start1),
    .c_base0(c_base0), .c_base1(c_base1),
    .c_len0(c_len0), .c_len1(c_len1),
    .gnt(gnt), .busy(busy), .r_addr(r_addr), .c_addr(c_addr),
    .mac_ena(mac_ena), .dump(dump), .sel(sel), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: last served requester and held idle outputs.
  int             last_srv;
  logic           m_sel;
  logic [PSZ-1:0] m_r;
  logic [CSZ-1:0] m_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] g, input logic b, input logic m,
                                     input logic d, input logic s, input logic [1:0] dn,
                                     input logic [PSZ-1:0] r, input logic [CSZ-1:0] c);
    return 32'({g, b, m, d, s, dn, r, c});
  endfunction

  function automatic logic [31:0] obs_vec();
    return mk(gnt, busy, mac_ena, dump, sel, done, r_addr, c_addr);
  endfunction

  function automatic int pick(input logic [1:0] rq);
`ifdef MAC_ARB_FIXED_PRIO_EN
    return rq[0] ? 0 : 1;
`else
    if (rq == 2'b11) return 1 - last_srv;
    return rq[0] ? 0 : 1;
`endif
  endfunction

  task automatic scramble_inputs(input bit with_req);
    r_start0 = PSZ'($urandom);
    r_start1 = PSZ'($urandom);
    c_base0  = CSZ'($urandom);
    c_base1  = CSZ'($urandom);
    c_len0   = CSZ'($urandom_range(0, 7));
    c_len1   = CSZ'($urandom_range(0, 7));
    if (with_req) req = 2'($urandom);
  endtask

  // Runs one burst starting from an idle negedge; g returns the observed first-cycle grant.
  task automatic burst(input logic [1:0] rq, input bit scr, output logic [1:0] g);
    int             w;
    int             n;
    int             kk;
    logic [PSZ-1:0] rs;
    logic [CSZ-1:0] cb;
    logic [CSZ-1:0] cl;
    logic [1:0]     oh;
    req = rq;
    w   = pick(rq);
    rs  = (w == 1) ? r_start1 : r_start0;
    cb  = (w == 1) ? c_base1 : c_base0;
    cl  = (w == 1) ? c_len1 : c_len0;
    oh  = (w == 1) ? 2'b10 : 2'b01;
    n   = 2 * (int'(cl) + 1);
    @(negedge clk);
    g = gnt;
    for (int k = 0; k < n + 2; k++) begin
      kk = (k < n) ? k : n - 1;
      check("burst", obs_vec(),
            mk(oh, 1'b1, (k < n), (k >= n), 1'(w), 2'b00,
               PSZ'(rs - PSZ'(kk)), CSZ'(cb + CSZ'(kk / 2))));
      if (scr) scramble_inputs(1'b1);
      @(negedge clk);
    end
    m_sel = 1'(w);
    m_r   = PSZ'(rs - PSZ'(n - 1));
    m_c   = CSZ'(cb + cl);
    check("done", obs_vec(), mk(2'b00, 1'b0, 1'b0, 1'b0, m_sel, oh, m_r, m_c));
    last_srv = w;
    req = 2'b00;
  endtask

  task automatic idle_cycle();
    req = 2'b00;
    @(negedge clk);
    check("idle", obs_vec(), mk(2'b00, 1'b0, 1'b0, 1'b0, m_sel, 2'b00, m_r, m_c));
  endtask

  logic [1:0] g;
  logic [1:0] rq;

  initial begin
    reset = 1'b1;
    req = 2'b00;
    r_start0 = '0; r_start1 = '0;
    c_base0 = '0; c_base1 = '0; c_len0 = '0; c_len1 = '0;
    last_srv = 1; m_sel = 1'b0; m_r = '0; m_c = '0;
    repeat (3) @(negedge clk);
    check("reset_state", obs_vec(), 32'd0);
    reset = 1'b0;
    idle_cycle();

    // Single burst with the documented address walk.
    r_start0 = 9'h0FF; c_base0 = 8'h00; c_len0 = 8'd3;
    burst(2'b01, 1'b0, g);
    check("single_gnt", 32'(g), 32'(2'b01));

    // Minimum length burst.
    c_len0 = 8'd0;
    burst(2'b01, 1'b0, g);

    // Address wrap on both pointers.
    r_start1 = 9'h001; c_base1 = 8'hFE; c_len1 = 8'd2;
    burst(2'b10, 1'b0, g);
    check("wrap_gnt", 32'(g), 32'(2'b10));
    idle_cycle();

    // Contention with both requests held.
    r_start0 = 9'h040; c_base0 = 8'h10; c_len0 = 8'd1;
    r_start1 = 9'h120; c_base1 = 8'h80; c_len1 = 8'd2;
    for (int i = 0; i < 4; i++) begin
      burst(2'b11, 1'b0, g);
`ifdef MAC_ARB_FIXED_PRIO_EN
      check("arb_order", 32'(g), 32'(2'b01));
`else
      check("arb_order", 32'(g), 32'((i % 2 == 1) ? 2'b10 : 2'b01));
`endif
    end

    // Reset in the third MACI cycle of a requester-1 burst.
    burst(2'b01, 1'b0, g);
    c_len1 = 8'd5;
    req = 2'b10;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid", obs_vec(), 32'd0);
    reset = 1'b0;
    last_srv = 1; m_sel = 1'b0; m_r = '0; m_c = '0;
    idle_cycle();
    burst(2'b11, 1'b0, g);
    check("post_reset_arb", 32'(g), 32'(2'b01));

    // Randomized bursts with inputs and requests disturbed mid-burst.
    for (int i = 0; i < 40; i++) begin
      scramble_inputs(1'b0);
      if ((i % 8) == 7) c_len0 = CSZ'($urandom_range(0, 255));
      rq = 2'($urandom);
      if (rq == 2'b00) idle_cycle();
      else burst(rq, 1'b1, g);
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
